credit_tx: RTL and testbench

Credit-based stream transmitter that drives the write end of a remote receive FIFO across a pipelined link with no backpressure wire. It accepts words on a valid/ready upstream handshake and forwards a word only while it holds a credit, so the receiver never overflows. Each credit represents one free receiver slot, and the receiver returns one credit per word it drains. The block sits between a local producer and a link register chain feeding the peer's FIFO.

---
 rtl/credit_pkg.sv | 13 +
 rtl/credit_tx_skid.sv | 73 +++++++
 rtl/credit_tx.sv | 98 +++++++++
 tb/tb_credit_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: shared definitions for the credit-based link (credit_tx today,
// credit_rx later).
//   credit_width(n)    - counter width able to hold 0..n
//   CREDIT_SKID_DEPTH  - entries in the transmitter skid buffer
package credit_pkg;

    localparam int CREDIT_SKID_DEPTH = 2;

    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/credit_tx_skid.sv
// credit_tx_skid: 2-entry skid buffer with a registered push_ready.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   push_valid/push_ready/push_data  - upstream side (push_ready registered)
//   pop_valid/pop_ready/pop_data     - head of buffer (pop_data = oldest word)
// A push and a pop in the same cycle keep occupancy and order unchanged.
module credit_tx_skid
    import credit_pkg::*;
#(
    parameter type TYPE = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    output logic push_ready,
    input  TYPE  push_data,
    output logic pop_valid,
    input  logic pop_ready,
    output TYPE  pop_data
);

    localparam int CW = $clog2(CREDIT_SKID_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDIT_SKID_DEPTH);

    TYPE           head;
    TYPE           tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          ready_q;
    logic          push;
    logic          pop;

    // ready comes from state only; it is also held low while rst is high so
    // nothing is accepted on the reset edge.
    assign push_ready = ready_q && !rst;
    assign pop_valid  = (count != '0);
    assign pop_data   = head;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next < FULL);
            if (pop) begin
                // With two held the tail moves up; with one held the head can
                // only be refilled by a simultaneous push (otherwise don't-care).
                head <= (count == FULL) ? tail : push_data;
                if (push)
                    tail <= push_data;
            end else if (push) begin
                if (count == '0)
                    head <= push_data;
                else
                    tail <= push_data;
            end
        end
    end

endmodule

// File: rtl/credit_tx.sv
// credit_tx: credit-based stream transmitter. Words accepted upstream are
// forwarded on the link only while a credit is held, one credit per word;
// the receiver returns one credit per drained word on credit_in.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   w_valid/w_ready     - upstream handshake (w_ready registered)
//   w_data              - upstream word
//   tx_valid/tx_data    - link output, one cycle per word, no backpressure
//   credit_in           - one credit returned this cycle
//   credits             - current credit count
//   overflow            - sticky: a credit came back while already full
// Build option CREDIT_TX_OUT_REG_EN: register tx_valid/tx_data (+1 cycle).
module credit_tx
    import credit_pkg::*;
#(
    parameter int  DATA_WIDTH   = 1,
    parameter type TYPE         = logic [DATA_WIDTH-1:0],
    parameter int  CREDITS      = 4,
    parameter int  CREDIT_WIDTH = credit_width(CREDITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  TYPE                     w_data,
    output logic                    tx_valid,
    output TYPE                     tx_data,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    overflow
);

    generate
        if (CREDITS < 1) begin : g_bad_credits
            $fatal(1, "credit_tx: CREDITS must be >= 1");
        end
    endgenerate

    localparam logic [CREDIT_WIDTH-1:0] CREDITS_MAX = CREDIT_WIDTH'(CREDITS);

    logic                    head_valid;
    TYPE                     head;
    logic                    fire;
    logic                    ovf_event;
    logic [CREDIT_WIDTH-1:0] credits_next;

    credit_tx_skid #(.TYPE(TYPE)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (w_valid),
        .push_ready (w_ready),
        .push_data  (w_data),
        .pop_valid  (head_valid),
        .pop_ready  (fire),
        .pop_data   (head)
    );

    // Only the registered count enables a send; a credit arriving this cycle
    // is usable next cycle. Nothing leaves while rst is high.
    assign fire      = head_valid && (credits != '0) && !rst;
    assign ovf_event = credit_in && !fire && (credits == CREDITS_MAX);

    always_comb begin
        credits_next = credits;
        if (fire && !credit_in)
            credits_next = credits - 1'b1;
        else if (!fire && credit_in && credits != CREDITS_MAX)
            credits_next = credits + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits  <= CREDITS_MAX;
            overflow <= 1'b0;
        end else begin
            credits <= credits_next;
            if (ovf_event)
                overflow <= 1'b1;
        end
    end

`ifdef CREDIT_TX_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= fire;
            if (fire)
                tx_data <= head;
        end
    end
`else
    assign tx_valid = fire;
    assign tx_data  = head;
`endif

endmodule

// File: tb/tb_credit_tx.sv
module tb_credit_tx;

    localparam int DW = 8;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);
`ifdef CREDIT_TX_OUT_REG_EN
    localparam int OUT_LAT = 1;
`else
    localparam int OUT_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_data = '0;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credits;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [DW-1:0] rxd[$];
    int            rxc[$];

    always #5 clk = ~clk;

    credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .credit_in (credit_in),
        .credits   (credits),
        .overflow  (overflow)
    );

    // Link capture: each word with the index of the edge closing its cycle.
    always @(posedge clk) begin
        if (tx_valid === 1'b1) begin
            rxd.push_back(tx_data);
            rxc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qd(input int i);
        return (i < rxd.size()) ? 32'(rxd[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (i < rxc.size()) ? 32'(rxc[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; returns the index of the accepting edge.
    task automatic push(input logic [DW-1:0] d, output int e);
        bit acc;
        acc = 1'b0;
        e = -1;
        w_valid = 1'b1;
        w_data  = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = w_ready;
            step();
        end
        w_valid = 1'b0;
        if (acc) e = cyc - 1;
        chk($sformatf("push_accept_%0d", d), 32'(acc), 32'd1);
    endtask

    initial begin
        int e;
        int e0;
        int ex;

        // Reset state
        @(negedge clk);
        chk("rst_w_ready", 32'(w_ready), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_credits", 32'(credits), CR);
        chk("rst_overflow", 32'(overflow), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_w_ready", 32'(w_ready), 1);

        // Burst 0..5, no credit return
        step();
        for (int d = 0; d < 6; d++) push(DW'(d), e);
        repeat (4) step();
        @(negedge clk);
        chk("burst_count", 32'(rxd.size()), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("burst_data_%0d", i), qd(i), i);
        chk("burst_credits", 32'(credits), 0);
        chk("burst_w_ready", 32'(w_ready), 0);

        // Single credit return releases word 4
        step();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        ex = cyc - 1;
        @(negedge clk);
        chk("ret1_credits_1", 32'(credits), 1);
        repeat (3) step();
        @(negedge clk);
        chk("ret1_count", 32'(rxd.size()), 5);
        chk("ret1_data", qd(4), 4);
        chk("ret1_latency", qc(4), ex + 1 + OUT_LAT);
        chk("ret1_credits_0", 32'(credits), 0);
        chk("ret1_w_ready", 32'(w_ready), 1);

        // Simultaneous fire and credit return at credits == 1
        step();
        push(8'd6, e);
        credit_in = 1'b1;
        step();
        @(negedge clk);
        chk("sim_credits_a", 32'(credits), 1);
        step();
        credit_in = 1'b0;
        ex = cyc - 1;
        @(negedge clk);
        chk("sim_credits_b", 32'(credits), 1);
        repeat (3) step();
        @(negedge clk);
        chk("sim_data5", qd(5), 5);
        chk("sim_data6", qd(6), 6);
        chk("sim_fire_cycle", qc(5), ex + OUT_LAT);
        chk("sim_next_cycle", qc(6), qc(5) + 1);
        chk("sim_credits_end", 32'(credits), 0);

        // Refill, then overflow
        step();
        credit_in = 1'b1;
        repeat (4) step();
        credit_in = 1'b0;
        @(negedge clk);
        chk("refill_credits", 32'(credits), CR);
        chk("refill_overflow", 32'(overflow), 0);
        step();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        @(negedge clk);
        chk("ovf_credits", 32'(credits), CR);
        chk("ovf_flag", 32'(overflow), 1);
        step();
        for (int d = 7; d < 11; d++) push(DW'(d), e);
        repeat (4) step();
        @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_traffic_count", 32'(rxd.size()), 11);
        for (int i = 7; i < 11; i++) chk($sformatf("ovf_data_%0d", i), qd(i), i);
        chk("ovf_credits_end", 32'(credits), 0);

        // Reset with two words held and credits == 1
        step();
        push(8'd11, e);
        push(8'd12, e);
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_credits", 32'(credits), 1);
        chk("mid_rst_tx_valid", 32'(tx_valid), 0);
        chk("mid_rst_w_ready", 32'(w_ready), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_tx_valid", 32'(tx_valid), 0);
        chk("after_rst_credits", 32'(credits), CR);
        chk("after_rst_w_ready", 32'(w_ready), 1);
        chk("after_rst_overflow", 32'(overflow), 0);
        repeat (4) step();
        @(negedge clk);
        chk("after_rst_no_tx", 32'(rxd.size()), 11);

        // Latency and sustained throughput over 4 words
        step();
        push(8'd20, e0);
        for (int d = 21; d < 24; d++) push(DW'(d), e);
        repeat (4) step();
        @(negedge clk);
        chk("tput_count", 32'(rxd.size()), 15);
        for (int i = 0; i < 4; i++) chk($sformatf("tput_data_%0d", i), qd(11 + i), 20 + i);
        chk("tput_latency", qc(11), e0 + 1 + OUT_LAT);
        chk("tput_rate", qc(14), qc(11) + 3);
        chk("tput_credits", 32'(credits), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
